// File: rtl/phase_sequencer.sv
// phase_sequencer
//
// Five-phase instruction-cycle sequencer for the SIMPLE CPU. It walks a one-hot
// phase vector through fetch (phases 1-2), hold (3-4) and complete (5). It keeps
// the program counter, the instruction register, the last load word and a
// retired-instruction count. A HLT instruction drops it back to idle.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   run          in   start request, honoured only while halted
//   memoryData   in   [15:0] synchronous memory read data
//   branchTaken  in   branch decision, sampled at the end of phase 5
//   branchTarget in   [15:0] branch destination, sampled with branchTaken
//   phase        out  [4:0] one-hot phase, 00000 while halted
//   IRData       out  [15:0] current instruction
//   PC           out  [15:0] program counter
//   loadData     out  [15:0] last word captured by a load
//   halted       out  high while idle
//   retired      out  [15:0] completed-instruction count

module phase_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] memoryData,
    input  logic        branchTaken,
    input  logic [15:0] branchTarget,
    output logic [4:0]  phase,
    output logic [15:0] IRData,
    output logic [15:0] PC,
    output logic [15:0] loadData,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [0:0] {StHalted, StRun} state_e;

    localparam logic [4:0] Ph1 = 5'b00001;
    localparam logic [4:0] Ph2 = 5'b00010;
    localparam logic [4:0] Ph3 = 5'b00100;
    localparam logic [4:0] Ph4 = 5'b01000;
    localparam logic [4:0] Ph5 = 5'b10000;

    state_e      state_q, state_d;
    logic [4:0]  phase_q, phase_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] load_q, load_d;
    logic [15:0] retired_q, retired_d;
    // Cleared by reset and set on the first edge afterwards, so a run that is
    // already high in the cycle reset is released does not start the machine.
    logic        armed_q;

    logic is_load;
    logic is_hlt;

    assign is_load = (ir_q[15:14] == 2'b00);
    assign is_hlt  = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'b1111);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StHalted;
            phase_q   <= 5'b00000;
            pc_q      <= 16'h0000;
            ir_q      <= 16'h0000;
            load_q    <= 16'h0000;
            retired_q <= 16'h0000;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            load_q    <= load_d;
            retired_q <= retired_d;
            armed_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        load_d    = load_q;
        retired_d = retired_q;

        unique case (state_q)
            StHalted: begin
                phase_d = 5'b00000;
                if (run && armed_q) begin
                    state_d = StRun;
                    phase_d = Ph1;
                end
            end
            StRun: begin
                unique case (phase_q)
                    Ph1: phase_d = Ph2;
                    Ph2: begin
                        ir_d    = memoryData;
                        pc_d    = pc_q + 16'd1;
                        phase_d = Ph3;
                    end
                    Ph3: phase_d = Ph4;
                    Ph4: phase_d = Ph5;
                    Ph5: begin
                        if (is_load) begin
                            load_d = memoryData;
                        end
                        retired_d = retired_q + 16'd1;
                        if (is_hlt) begin
                            state_d = StHalted;
                            phase_d = 5'b00000;
                        end else begin
                            if (branchTaken) begin
                                pc_d = branchTarget;
                            end
                            phase_d = Ph1;
                        end
                    end
                    default: begin
                        // Unreachable encoding: park safely in idle.
                        state_d = StHalted;
                        phase_d = 5'b00000;
                    end
                endcase
            end
            default: begin
                state_d = StHalted;
                phase_d = 5'b00000;
            end
        endcase
    end

    assign phase    = phase_q;
    assign IRData   = ir_q;
    assign PC       = pc_q;
    assign loadData = load_q;
    assign halted   = (state_q == StHalted);
    assign retired  = retired_q;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Drives the five-phase instruction cycle for the SIMPLE CPU. It generates the one-hot `phase` vector, the program counter `PC` and the latched instruction register `IRData` consumed by the memory wrapper and the datapath. It captures instruction words and load data from the synchronous memory's `memoryData`, and stops cleanly on a HLT instruction.

## Interface
- No parameters. Data width is fixed at 16 bits and phase width at 5 bits.
- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `run`  in  1  start request; sampled only while halted
- `memoryData`  in  16  synchronous memory read data, valid one cycle after the address phase
- `branchTaken`  in  1  branch decision from the datapath, sampled at the end of phase 5
- `branchTarget`  in  16  branch destination, sampled together with `branchTaken`
- `phase`  out  5  one-hot phase: 00001, 00010, 00100, 01000, 10000; 00000 when halted
- `IRData`  out  16  current instruction
- `PC`  out  16  program counter (memory address in phase 1)
- `loadData`  out  16  last word captured by a load instruction
- `halted`  out  1  high while the sequencer is idle
- `retired`  out  16  count of completed instructions

## Operation
- States:
  - HALTED: `phase` = 00000, `halted` = 1.
  - RUN: `phase` rotates 00001 → 00010 → 00100 → 01000 → 10000 → 00001.
- HALTED → RUN: on `run` = 1. The next cycle has `phase` = 00001. `run` is ignored in RUN.
- Phase 1: `PC` drives the memory address. The sequencer does nothing else.
- End of phase 2:
  - `IRData` <= `memoryData` (the fetched word).
  - `PC` <= `PC` + 1, modulo 2^16 (FFFF wraps to 0000).
- Phases 3 and 4: hold. In phase 4 the memory receives DR for a load or store.
- End of phase 5, evaluated in priority order:
  1. If the instruction is a load (`IRData[15:14]` = 00), `loadData` <= `memoryData`.
  2. `retired` <= `retired` + 1, wrapping at 16 bits. This applies to every instruction, HLT included.
  3. If the instruction is HLT (`IRData[15:14]` = 11 and `IRData[7:4]` = 1111), go to HALTED. `PC` keeps its value and `branchTaken` is ignored.
  4. Otherwise, if `branchTaken` = 1, `PC` <= `branchTarget` and `phase` <= 00001.
  5. Otherwise `phase` <= 00001.
- `PC`, `IRData` and `loadData` change only at the points listed above.
- A store (`IRData[15:14]` = 01) needs no action here; the write happens in phase 4 in the memory wrapper.
- Reset values: `phase` = 00000, `halted` = 1, `PC` = 0000, `IRData` = 0000, `loadData` = 0000, `retired` = 0000.
- Reset mid-instruction: state clears asynchronously and the current instruction is abandoned without retiring. After reset is released the sequencer waits for `run`.
- `reset` and `run` asserted together: reset wins.
- Restart after HLT: a new `run` resumes fetch at the held `PC`, which already points past the HLT.

## Timing
- `run` sampled high in HALTED at edge N → `phase` = 00001 after edge N.
- Each instruction takes exactly 5 cycles. Back-to-back instructions have no bubble: phase 5 is followed directly by phase 1.
- Fetch latency: the address is registered by memory at the end of phase 1. `memoryData` is valid throughout phase 2. `IRData` updates at the end of phase 2 and is stable from phase 3 through phase 2 of the next instruction.
- Load latency: DR is registered at the end of phase 4. `memoryData` is valid in phase 5. `loadData` updates at the end of phase 5.
- `halted` and `phase` are registered outputs with no combinational path from inputs.
- After a HLT, `halted` = 1 on the cycle following that instruction's phase 5.

## Test plan
- Reset, then run: memory[0] = 0x0000 (load), memory at DR = 0xBEEF.
  - `phase` sequence is 00001, 00010, 00100, 01000, 10000.
  - `IRData` = 0x0000 after cycle 2 and `PC` = 0001.
  - `loadData` = 0xBEEF after cycle 5 and `retired` = 1.
- Program memory[0] = ALU op, memory[1] = 0xC0F0 (HLT).
  - `halted` rises after cycle 10.
  - `PC` = 0002, `retired` = 2, `phase` = 00000.
  - Holding `run` = 0 keeps it idle.
  - A later `run` pulse resumes fetch at `PC` = 0002.
- Assert `branchTaken` = 1 with `branchTarget` = 0x0040 during phase 5 of the instruction at 0x0010 → the next phase 1 shows `PC` = 0x0040. The same stimulus on a HLT leaves `PC` = 0x0011.
- Preload `PC` to 0xFFFF via a branch and fetch a non-branch instruction → `PC` = 0x0000 after phase 2.
- Assert `reset` during phase 3 → all outputs return immediately to their reset values. `run` asserted in the same cycle as the `reset` release has no effect; `run` one cycle later starts at `PC` = 0000.
- Run 65536 non-halting instructions → `retired` wraps from 0xFFFF to 0x0000.
